// File: rtl/snake_tick_gen_pkg.sv
// Purpose : shared constants for the snake tick generator.
//           Channel indices name the role of each tick channel; the DEF_*
//           values are the default parameters of snake_tick_gen.
package snake_tick_gen_pkg;

  localparam int CH_GAME = 0;  // game step, divisor scaled by speed level
  localparam int CH_SCAN = 1;  // seven-segment digit scan
  localparam int CH_DEB  = 2;  // debounce sample

  localparam int          DEF_NUM_CH     = 3;
  localparam int          DEF_CNT_W      = 27;
  localparam int          DEF_LVL_W      = 3;
  localparam int          DEF_MAX_LVL    = 7;
  localparam logic [2:0]  DEF_PAUSE_MASK = 3'b101;

  localparam int          SCAN_W         = 2;

endpackage

// File: rtl/snake_tick_chan.sv
// Purpose : one tick channel. The counter runs 0 .. E-1 and emits a
//           one-cycle registered strobe on the wrap, where E = div_i >> lvl_i
//           (E of 0 or 1 behaves as 1). When PAUSABLE is set and pause_i is
//           high, the count holds and the strobe is suppressed.
// Ports   : clk_i   - clock, rising edge
//           rst_i   - asynchronous active-high reset
//           div_i   - base divisor
//           lvl_i   - right-shift applied to div_i (tie to 0 for no scaling)
//           pause_i - level-sensitive freeze request
//           tick_o  - registered one-cycle strobe
module snake_tick_chan
  import snake_tick_gen_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LVL_W    = DEF_LVL_W,
  parameter bit PAUSABLE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [LVL_W-1:0] lvl_i,
  input  logic             pause_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] eff_div;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             run;

  always_comb begin
    eff_div = div_i >> lvl_i;
    // Divisors 0 and 1 both collapse to a limit of 0: tick every active cycle.
    limit   = (eff_div <= CNT_W'(1)) ? '0 : eff_div - CNT_W'(1);
    run     = !(PAUSABLE && pause_i);
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (run) begin
      // >= (not ==) so a divisor shrinking below the current count wraps
      // immediately instead of running past the limit.
      if (cnt_q >= limit) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/snake_tick_gen.sv
// Purpose : multi-channel tick generator for the snake game board.
//           Channel CH_GAME is sped up by the registered speed level;
//           scan_sel advances once per CH_SCAN tick.
// Ports   : board_clk - clock, rising edge
//           reset     - asynchronous active-high reset
//           div_val   - per-channel base divisor, channel i at [i*CNT_W +: CNT_W]
//           pause     - freezes channels whose PAUSE_MASK bit is set
//           speed_up  - one-cycle request: level + 1, saturating at MAX_LVL
//           level_clr - one-cycle request: level = 0 (wins over speed_up)
//           tick      - registered one-cycle strobes, one per channel
//           level     - current speed level
//           scan_sel  - seven-segment digit select
module snake_tick_gen
  import snake_tick_gen_pkg::*;
#(
  parameter int                NUM_CH     = DEF_NUM_CH,
  parameter int                CNT_W      = DEF_CNT_W,
  parameter int                LVL_W      = DEF_LVL_W,
  parameter int                MAX_LVL    = DEF_MAX_LVL,
  parameter logic [NUM_CH-1:0] PAUSE_MASK = DEF_PAUSE_MASK
) (
  input  logic                    board_clk,
  input  logic                    reset,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic                    pause,
  input  logic                    speed_up,
  input  logic                    level_clr,
  output logic [NUM_CH-1:0]       tick,
  output logic [LVL_W-1:0]        level,
  output logic [SCAN_W-1:0]       scan_sel
);

  logic [LVL_W-1:0]  level_q, level_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [NUM_CH-1:0] tick_w;
  logic              scan_adv;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    logic [LVL_W-1:0] ch_lvl;
    // Only the game channel is scaled by the speed level.
    assign ch_lvl = (i == CH_GAME) ? level_q : '0;

    snake_tick_chan #(
      .CNT_W    (CNT_W),
      .LVL_W    (LVL_W),
      .PAUSABLE (PAUSE_MASK[i])
    ) u_chan (
      .clk_i   (board_clk),
      .rst_i   (reset),
      .div_i   (div_val[i*CNT_W +: CNT_W]),
      .lvl_i   (ch_lvl),
      .pause_i (pause),
      .tick_o  (tick_w[i])
    );
  end

  if (NUM_CH > CH_SCAN) begin : g_scan
    assign scan_adv = tick_w[CH_SCAN];
  end else begin : g_no_scan
    assign scan_adv = 1'b0;
  end

  always_comb begin
    level_d = level_q;
    if (level_clr) begin
      level_d = '0;
    end else if (speed_up && (level_q < LVL_W'(MAX_LVL))) begin
      level_d = level_q + LVL_W'(1);
    end
    // Wraps naturally modulo 4 in SCAN_W bits.
    scan_d = scan_q + {{(SCAN_W-1){1'b0}}, scan_adv};
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      scan_q  <= '0;
    end else begin
      level_q <= level_d;
      scan_q  <= scan_d;
    end
  end

  assign tick     = tick_w;
  assign level    = level_q;
  assign scan_sel = scan_q;

endmodule

// File: tb/tb_snake_tick_gen.sv
module tb_snake_tick_gen;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 27;
  localparam int LVL_W   = 3;
  localparam int MAX_LVL = 7;
  localparam int DW      = NUM_CH * CNT_W;

  logic              board_clk = 1'b0;
  logic              reset     = 1'b1;
  logic [DW-1:0]     div_val   = '0;
  logic              pause     = 1'b0;
  logic              speed_up  = 1'b0;
  logic              level_clr = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [LVL_W-1:0]  level;
  logic [1:0]        scan_sel;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [NUM_CH-1:0] t;
    int                l;
    int                s;
  } exp_t;

  exp_t sb[$];

  // reference model state: cycles elapsed in current period, level, scan
  int                m_cnt[NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  int                m_lvl;
  int                m_scan;
  logic [NUM_CH-1:0] pmask = 3'b101;

  snake_tick_gen dut (
    .board_clk (board_clk),
    .reset     (reset),
    .div_val   (div_val),
    .pause     (pause),
    .speed_up  (speed_up),
    .level_clr (level_clr),
    .tick      (tick),
    .level     (level),
    .scan_sel  (scan_sel)
  );

  always #5 board_clk = ~board_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_div(input int d0, input int d1, input int d2);
    logic [DW-1:0] v;
    v = '0;
    v[0*CNT_W +: CNT_W] = CNT_W'(d0);
    v[1*CNT_W +: CNT_W] = CNT_W'(d1);
    v[2*CNT_W +: CNT_W] = CNT_W'(d2);
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
    m_tick = '0;
    m_lvl  = 0;
    m_scan = 0;
  endtask

  // Predict the outputs after the next rising edge from the currently driven inputs.
  task automatic model_step();
    logic [NUM_CH-1:0] nt;
    exp_t e;
    int per;
    nt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      per = int'(div_val[c*CNT_W +: CNT_W]);
      if (c == 0) per = per >> m_lvl;
      if (per < 1) per = 1;
      if (pause && pmask[c]) begin
        nt[c] = 1'b0;
      end else if (m_cnt[c] + 1 >= per) begin
        nt[c]    = 1'b1;
        m_cnt[c] = 0;
      end else begin
        m_cnt[c] = m_cnt[c] + 1;
      end
    end
    if (m_tick[1]) m_scan = (m_scan + 1) % 4;
    if (level_clr)     m_lvl = 0;
    else if (speed_up) m_lvl = (m_lvl < MAX_LVL) ? m_lvl + 1 : MAX_LVL;
    m_tick = nt;
    e.t = nt;
    e.l = m_lvl;
    e.s = m_scan;
    sb.push_back(e);
  endtask

  task automatic apply(input logic [DW-1:0] d, input logic p, input logic su, input logic clr);
    div_val   = d;
    pause     = p;
    speed_up  = su;
    level_clr = clr;
    model_step();
  endtask

  task automatic cyc(input logic [DW-1:0] d, input logic p, input logic su, input logic clr);
    @(negedge board_clk);
    apply(d, p, su, clr);
  endtask

  task automatic run(input logic [DW-1:0] d, input int n);
    for (int k = 0; k < n; k++) cyc(d, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges, check outputs clear at once, release at a negedge.
  task automatic mid_reset(input logic [DW-1:0] d);
    @(negedge board_clk);
    #2;
    reset = 1'b1;
    sb.delete();
    model_reset();
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_scan", int'(scan_sel), 0);
    @(negedge board_clk);
    @(negedge board_clk);
    reset = 1'b0;
    apply(d, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor: every edge out of reset must match the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge board_clk);
      #1;
      if (!reset) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow at %0t: actual=empty required=entry", $time);
        end else begin
          e = sb.pop_front();
          chk("tick", int'(tick), int'(e.t));
          chk("level", int'(level), e.l);
          chk("scan_sel", int'(scan_sel), e.s);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    model_reset();
    #1;
    chk("init_tick", int'(tick), 0);
    chk("init_level", int'(level), 0);
    chk("init_scan", int'(scan_sel), 0);

    // basic periods 4/3/1
    d = mk_div(4, 3, 1);
    @(negedge board_clk);
    reset = 1'b0;
    apply(d, 1'b0, 1'b0, 1'b0);
    run(d, 13);

    // speed levels on base 16
    d = mk_div(16, 3, 2);
    mid_reset(d);
    for (int k = 0; k < 3; k++) cyc(d, 1'b0, 1'b1, 1'b0);
    @(posedge board_clk);
    #2;
    chk("lvl_after_3", int'(level), 3);
    run(d, 8);
    for (int k = 0; k < 5; k++) cyc(d, 1'b0, 1'b1, 1'b0);
    @(posedge board_clk);
    #2;
    chk("lvl_sat", int'(level), MAX_LVL);
    run(d, 6);

    // coincident speed_up and level_clr at level 5
    cyc(d, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cyc(d, 1'b0, 1'b1, 1'b0);
    cyc(d, 1'b0, 1'b1, 1'b1);
    @(posedge board_clk);
    #2;
    chk("lvl_clr_wins", int'(level), 0);

    // pause ch0=10 at count 6 for 20 cycles
    d = mk_div(10, 3, 5);
    mid_reset(d);
    run(d, 5);
    for (int k = 0; k < 20; k++) cyc(d, 1'b1, 1'b0, 1'b0);
    run(d, 12);

    // ch1 divisor 8 -> 4 at count 6
    d = mk_div(7, 8, 2);
    mid_reset(d);
    run(d, 5);
    d = mk_div(7, 4, 2);
    run(d, 18);

    // async reset at ch0 count 5, level 2, then first tick after 64 edges
    d = mk_div(64, 5, 3);
    mid_reset(d);
    cyc(d, 1'b0, 1'b1, 1'b0);
    cyc(d, 1'b0, 1'b1, 1'b0);
    run(d, 2);
    mid_reset(d);
    run(d, 66);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      if (k % 25 == 0)
        d = mk_div($urandom_range(40, 0), $urandom_range(12, 0), $urandom_range(12, 0));
      if (k == 300) begin
        mid_reset(d);
      end else begin
        cyc(d, ($urandom_range(7, 0) == 0), ($urandom_range(5, 0) == 0),
            ($urandom_range(15, 0) == 0));
      end
    end

    @(posedge board_clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_tick_gen.md
SNAKE_TICK_GEN -- requirements
Module: snake_tick_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3: number of independent tick channels (ch0 game step, ch1 SSD scan, ch2 debounce sample).
REQ-002 The block SHALL have parameter CNT_W, default 27: divisor and counter width per channel.
REQ-003 The block SHALL have parameter LVL_W, default 3: speed-level width.
REQ-004 The block SHALL have parameter MAX_LVL, default 7: speed-level saturation value, at most 2^LVL_W-1.
REQ-005 The block SHALL have parameter PAUSE_MASK, default 3'b101: bit i set means channel i freezes while pause is high.
REQ-006 The block SHALL have port board_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port div_val, input, NUM_CH*CNT_W bits: per-channel base divisor, channel i in bits [i*CNT_W +: CNT_W].
REQ-009 The block SHALL have port pause, input, 1 bit: level-sensitive freeze of masked channels.
REQ-010 The block SHALL have port speed_up, input, 1 bit: single-cycle request to raise the speed level by one.
REQ-011 The block SHALL have port level_clr, input, 1 bit: single-cycle request to return the speed level to 0.
REQ-012 The block SHALL have port tick, output, NUM_CH bits: registered one-cycle strobes.
REQ-013 The block SHALL have port level, output, LVL_W bits: current speed level, registered.
REQ-014 The block SHALL have port scan_sel, output, 2 bits: SSD digit select, advancing on each ch1 tick.

Function
REQ-015 Each channel SHALL keep counter cnt[i] of CNT_W bits with effective divisor E[i], where E[i] = div_val[i] for i>0 and E[0] = div_val[0] >> level.
REQ-016 E[i] values of 0 or 1 SHALL be treated as 1, giving a tick on every active cycle.
REQ-017 On each active cycle, if cnt[i] >= E[i]-1, the channel SHALL set cnt[i] to 0 and tick[i] to 1; otherwise it SHALL increment cnt[i] and set tick[i] to 0.
REQ-018 Tick period SHALL be exactly E[i] cycles; the first tick SHALL appear on the E[i]-th rising edge after reset release.
REQ-019 A divisor or level change mid-count SHALL take effect on the next edge; if cnt[i] is already >= the new E[i]-1, the channel SHALL tick and wrap on that edge, with no count past the limit.
REQ-020 While pause is 1, masked channels SHALL hold cnt[i] and drive tick[i] to 0; unmasked channels SHALL run normally.
REQ-021 Deasserting pause SHALL resume counting from the held value without losing or inserting a tick.
REQ-022 On a speed_up pulse, level SHALL increment by 1 and saturate at MAX_LVL; a speed_up received at MAX_LVL SHALL be ignored.
REQ-023 On a level_clr pulse, level SHALL become 0; if speed_up and level_clr coincide, level_clr SHALL win.
REQ-024 A level change SHALL alter E[0] starting with the cycle after the registering edge.
REQ-025 scan_sel SHALL increment modulo 4 on each cycle in which tick[1] is 1; it SHALL not be affected by pause unless PAUSE_MASK[1] is set.

Reset
REQ-026 Asserting reset SHALL immediately clear all cnt[i], tick, level and scan_sel to 0, including mid-period and while paused.
REQ-027 After reset deassertion, counting SHALL start on the first rising edge at which reset is low.

Structure
REQ-028 A shared package SHALL hold the channel index constants (CH_GAME=0, CH_SCAN=1, CH_DEB=2) and the default parameter values.
REQ-029 A single sub-module, snake_tick_chan, SHALL implement one counter channel (E, pause gate, tick) and SHALL be instantiated NUM_CH times by a generate loop; level and scan_sel logic SHALL stay in the parent.

Verification
REQ-030 The bench SHALL cover: div_val ch0=4, ch1=3, ch2=1, level 0 -> tick[0] on edges 4,8,12; tick[1] on 3,6,9; tick[2] on every edge.
REQ-031 The bench SHALL cover: ch0 base 16, three speed_up pulses -> level=3, E[0]=2; a fourth through eighth pulse -> level saturates at 7, E[0] treated as 1.
REQ-032 The bench SHALL cover: speed_up and level_clr on the same cycle at level 5 -> level=0.
REQ-033 The bench SHALL cover: ch0=10, pause high for 20 cycles starting at cnt=6 -> no tick[0], cnt holds 6; ch1 keeps ticking; after release, tick[0] appears 4 edges later.
REQ-034 The bench SHALL cover: ch1=8 at cnt=6, div changed to 4 -> tick on next edge, then period 4; scan_sel steps 0,1,2,3,0.
REQ-035 The bench SHALL cover: reset asserted asynchronously between edges at cnt=5, level=2 -> all outputs 0 before the next edge; first tick at E edges after release.
